// File: rtl/mat_pkg.sv
// Shared types and helpers for the matrix-inverse path: FSM encoding, the
// reciprocal iteration count, and the saturation limits.
package mat_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    // Quotient bits needed for floor(2^(2*bin_pos) / |det|)
    function automatic int recip_iter(input int bin_pos);
        return 2 * bin_pos + 1;
    endfunction

    function automatic longint unsigned sat_max_pos(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic longint unsigned sat_max_neg(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift a numerator bit into the
// remainder and subtract the divisor when it fits.
module div_step #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rem_in,
    input  logic                  num_bit,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] rem_out,
    output logic                  q_bit
);

    logic [DATA_WIDTH:0] trial;
    logic [DATA_WIDTH:0] diff;

    // The remainder stays below the divisor, so one extra bit covers the shift
    always_comb begin
        trial   = {rem_in, num_bit};
        diff    = trial - {1'b0, divisor};
        q_bit   = (trial >= {1'b0, divisor});
        rem_out = q_bit ? diff[DATA_WIDTH-1:0] : trial[DATA_WIDTH-1:0];
    end

endmodule

// File: rtl/det_reciprocal.sv
// Sequential signed fixed-point reciprocal of a determinant, one quotient bit
// per clock. Define DET_RECIP_ROUND_EN for round-half-up instead of truncation.
module det_reciprocal
    import mat_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int BIN_POS    = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] det,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] recip,
    output logic                         singular,
    output logic                         overflow
);

    localparam int ITER = recip_iter(BIN_POS);
`ifdef DET_RECIP_ROUND_EN
    localparam int STEPS = ITER + 1;
`else
    localparam int STEPS = ITER;
`endif
    localparam int CNT_W = $clog2(ITER + 2);
    localparam int QW    = ITER + 1;
    localparam int EW    = ((QW > DATA_WIDTH) ? QW : DATA_WIDTH) + 1;

    localparam logic [DATA_WIDTH-1:0] MAX_POS = DATA_WIDTH'(sat_max_pos(DATA_WIDTH));
    localparam logic [DATA_WIDTH-1:0] MAX_NEG = DATA_WIDTH'(sat_max_neg(DATA_WIDTH));

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic                    out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]   recip_q, recip_d;
    logic                    singular_q, singular_d;
    logic                    overflow_q, overflow_d;

    logic                    neg_q, neg_d;
    logic [DATA_WIDTH-1:0]   divisor_q, divisor_d;
    logic [DATA_WIDTH-1:0]   rem_q, rem_d;
    logic [QW-1:0]           quo_q, quo_d;

    logic                    num_bit;
    logic [DATA_WIDTH-1:0]   step_rem;
    logic                    step_q;

    function automatic logic [QW-1:0] round_mag(input logic [QW-1:0] q);
`ifdef DET_RECIP_ROUND_EN
        // q carries one extra fraction bit; add it back as round-half-up
        return (q >> 1) + QW'(q[0]);
`else
        return q;
`endif
    endfunction

    // Returns {overflow, recip}
    function automatic logic [DATA_WIDTH:0] saturate(input logic neg,
                                                     input logic [QW-1:0] mag);
        logic [EW-1:0] m;
        logic [EW-1:0] neg_m;
        m     = EW'(mag);
        neg_m = -m;
        if (!neg && m > EW'(MAX_POS)) return {1'b1, MAX_POS};
        if (neg && m > EW'(MAX_NEG))  return {1'b1, MAX_NEG};
        return {1'b0, neg ? neg_m[DATA_WIDTH-1:0] : m[DATA_WIDTH-1:0]};
    endfunction

    // The numerator is a single 1 followed by zeros, shifted in MSB first
    assign num_bit = (cnt_q == CNT_W'(STEPS - 1));

    div_step #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_div_step (
        .rem_in (rem_q),
        .num_bit(num_bit),
        .divisor(divisor_q),
        .rem_out(step_rem),
        .q_bit  (step_q)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        out_valid_d = 1'b0;
        recip_d     = recip_q;
        singular_d  = singular_q;
        overflow_d  = overflow_q;
        neg_d       = neg_q;
        divisor_d   = divisor_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    singular_d = (det == '0);
                    overflow_d = 1'b0;
                    neg_d      = det[DATA_WIDTH-1];
                    divisor_d  = det[DATA_WIDTH-1] ? -det : det;
                    rem_d      = '0;
                    quo_d      = '0;
                    cnt_d      = CNT_W'(STEPS - 1);
                    if (det == '0) begin
                        recip_d = MAX_POS;
                        state_d = DONE;
                    end else begin
                        state_d = DIV;
                    end
                end
            end
            DIV: begin
                rem_d = step_rem;
                quo_d = {quo_q[QW-2:0], step_q};
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) state_d = FIX;
            end
            FIX: begin
                {overflow_d, recip_d} = saturate(neg_q, round_mag(quo_q));
                state_d = DONE;
            end
            DONE: begin
                out_valid_d = 1'b1;
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            recip_q     <= '0;
            singular_q  <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            recip_q     <= recip_d;
            singular_q  <= singular_d;
            overflow_q  <= overflow_d;
        end
    end

    // Working registers are always initialised on accept, so they carry no reset
    always_ff @(posedge clk) begin
        neg_q     <= neg_d;
        divisor_q <= divisor_d;
        rem_q     <= rem_d;
        quo_q     <= quo_d;
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign recip     = recip_q;
    assign singular  = singular_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_det_reciprocal.sv
// Scoreboard bench for det_reciprocal at DATA_WIDTH=32, BIN_POS=16.
module tb_det_reciprocal;

    localparam int W = 32;
`ifdef DET_RECIP_ROUND_EN
    localparam int LAT = 36;
`else
    localparam int LAT = 35;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] det;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] recip;
    logic         singular;
    logic         overflow;

    int          n_vec = 0;
    int          n_err = 0;
    logic [33:0] sb[$];

    always #5 clk = ~clk;

    det_reciprocal #(
        .DATA_WIDTH(32),
        .BIN_POS   (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .det      (det),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .recip    (recip),
        .singular (singular),
        .overflow (overflow)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns {singular, overflow, recip}
    function automatic logic [33:0] model(input logic [31:0] d);
        longint unsigned m;
        longint unsigned q;
        if (d == 32'd0) return {2'b10, 32'h7FFF_FFFF};
        m = d[31] ? (64'h1_0000_0000 - {32'd0, d}) : {32'd0, d};
`ifdef DET_RECIP_ROUND_EN
        q = ((64'd1 << 33) / m + 64'd1) >> 1;
`else
        q = (64'd1 << 32) / m;
`endif
        if (!d[31]) begin
            if (q > 64'h7FFF_FFFF) return {2'b01, 32'h7FFF_FFFF};
            return {2'b00, q[31:0]};
        end
        if (q > 64'h8000_0000) return {2'b01, 32'h8000_0000};
        q = 64'h1_0000_0000 - q;
        return {2'b00, q[31:0]};
    endfunction

    task automatic do_txn(input logic [31:0] d, input int hold);
        logic [33:0] e;
        int          cyc;
        int          lat;
        @(negedge clk);
        check("in_ready_idle", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        det      = d;
        sb.push_back(model(d));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        lat = (d == 32'd0) ? 1 : LAT;
        check("latency", 64'(cyc), 64'(lat));
        e = sb.pop_front();
        check("recip", {32'd0, recip}, {32'd0, e[31:0]});
        check("singular", {63'd0, singular}, {63'd0, e[33]});
        check("overflow", {63'd0, overflow}, {63'd0, e[32]});
        check("in_ready_done", {63'd0, in_ready}, 64'd0);
        repeat (hold) begin
            @(posedge clk);
            #1;
            check("hold_recip", {32'd0, recip}, {32'd0, e[31:0]});
            check("hold_flags", {62'd0, singular, overflow}, {62'd0, e[33:32]});
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("valid_drop", {63'd0, out_valid}, 64'd0);
        check("back_idle", {63'd0, in_ready}, 64'd1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        det       = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", {63'd0, out_valid}, 64'd0);
        check("rst_recip", {32'd0, recip}, 64'd0);
        check("rst_flags", {62'd0, singular, overflow}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);
        @(negedge clk);
        rst = 1'b0;

        do_txn(32'h0002_0000, 0);
        do_txn(32'hFFFC_0000, 0);
        do_txn(32'h0001_8000, 0);
        do_txn(32'h0000_0000, 0);
        do_txn(32'h0000_0001, 0);
        do_txn(32'hFFFF_FFFF, 0);
        do_txn(32'h8000_0000, 0);
        do_txn(32'h0003_0000, 5);

        // Abort during DIV
        @(negedge clk);
        in_valid = 1'b1;
        det      = 32'h0003_0000;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("pre_abort_busy", {63'd0, in_ready}, 64'd0);
        rst = 1'b1;
        #1;
        check("abort_valid", {63'd0, out_valid}, 64'd0);
        check("abort_in_ready", {63'd0, in_ready}, 64'd1);
        check("abort_recip", {32'd0, recip}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_txn(32'h0001_0000, 0);

        // Determinants of random small-integer 2x2 matrices in Q16
        for (int i = 0; i < 20; i++) begin
            int a, b, c, dd, dt;
            a  = int'($urandom_range(0, 15)) - 8;
            b  = int'($urandom_range(0, 15)) - 8;
            c  = int'($urandom_range(0, 15)) - 8;
            dd = int'($urandom_range(0, 15)) - 8;
            dt = (a * dd - b * c) * 65536;
            do_txn(32'(dt), int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < 15; i++) begin
            logic [31:0] r;
            r = $urandom;
            if (i % 3 == 0) r = r >> 20;
            if (i % 5 == 0) r = -(r >> 24);
            do_txn(r, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
